// File: rtl/vga_pkg.sv
// Shared types and constants for the VGA span fetch engine.
package vga_pkg;

    typedef enum logic [1:0] {
        SYNC       = 2'd0,
        BACKPORCH  = 2'd1,
        ACTIVE     = 2'd2,
        FRONTPORCH = 2'd3
    } vga_state_t;

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } fetch_state_t;

    localparam int PIX_PER_WORD = 32;
    localparam int DEFAULT_FETCH_OFFSET = 16;
    localparam logic [4:0] SPAN_LAST = 5'(PIX_PER_WORD - 1);

endpackage

// File: rtl/vga_data_controller_if.sv
// SRAM-side request/response bundle between the fetch engine and the arbiter.
interface vga_data_controller_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              read;
    logic [3:0]        byte_select_out;
    logic [ADDR_W-1:0] SRAM_address;
    logic [DATA_W-1:0] data_from_SRAM;
    logic              data_en;
    logic [3:0]        byte_select_in;

    modport master (
        output read,
        output byte_select_out,
        output SRAM_address,
        input  data_from_SRAM,
        input  data_en,
        input  byte_select_in
    );

    modport slave (
        input  read,
        input  byte_select_out,
        input  SRAM_address,
        output data_from_SRAM,
        output data_en,
        output byte_select_in
    );
endinterface

// File: rtl/vga_data_controller.sv
// Prefetches one 1-bpp word per 32-pixel span from SRAM, half a span early,
// and hands it to the pixel serializer exactly at the span boundary.
module vga_data_controller
    import vga_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int FETCH_OFFSET = DEFAULT_FETCH_OFFSET
) (
    input  logic                    clk,
    input  logic                    nrst,
    input  logic [ADDR_W-1:0]       VGA_request_address,
    input  logic [9:0]              h_count,
    input  logic [1:0]              VGA_state,
    output logic [DATA_W-1:0]       data_to_VGA,
    vga_data_controller_if.master   sram
);

    localparam logic [4:0] LAUNCH_POS = 5'(FETCH_OFFSET);

    fetch_state_t      state, state_next;
    vga_state_t        phase;
    logic [4:0]        span_pos;
    logic              visible;
    logic              launch_hit;
    logic              present_hit;
    logic              capture;
    logic              read_q, read_next;
    logic [3:0]        bse_q, bse_next;
    logic [ADDR_W-1:0] addr_q, addr_next;
    logic [DATA_W-1:0] fetch_buf;
    logic              buf_valid;
    logic              unused_h_count;

    // Keeps only the byte lanes the arbiter marked valid; other lanes read as blank.
    function automatic logic [DATA_W-1:0] mask_bytes(input logic [DATA_W-1:0] d,
                                                     input logic [3:0] sel);
        logic [DATA_W-1:0] m;
        m = '0;
        for (int k = 0; k < 4; k++) begin
            if (sel[k]) m[8*k +: 8] = d[8*k +: 8];
        end
        return m;
    endfunction

    assign phase          = vga_state_t'(VGA_state);
    assign span_pos       = h_count[4:0];
    assign unused_h_count = ^h_count[9:5];
    assign visible        = (phase == BACKPORCH) || (phase == ACTIVE);
    assign launch_hit     = visible && (span_pos == LAUNCH_POS);
    assign present_hit    = visible && (span_pos == SPAN_LAST);

    assign sram.read            = read_q;
    assign sram.byte_select_out = bse_q;
    assign sram.SRAM_address    = addr_q;

    // Next-state and registered-output decode for the fetch request FSM.
    always_comb begin
        state_next = state;
        read_next  = read_q;
        bse_next   = bse_q;
        addr_next  = addr_q;
        capture    = 1'b0;
        case (state)
            IDLE: begin
                if (launch_hit) begin
                    state_next = REQ;
                    read_next  = 1'b1;
                    bse_next   = 4'hF;
                    addr_next  = VGA_request_address;
                end
            end
            REQ: begin
                if (!visible || (present_hit && !sram.data_en)) begin
                    state_next = IDLE;
                    read_next  = 1'b0;
                    bse_next   = 4'h0;
                end else if (sram.data_en) begin
                    capture    = 1'b1;
                    state_next = IDLE;
                    read_next  = 1'b0;
                    bse_next   = 4'h0;
                end
            end
            default: begin
                state_next = IDLE;
                read_next  = 1'b0;
                bse_next   = 4'h0;
            end
        endcase
    end

    // FSM state and request-side output registers.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state  <= IDLE;
            read_q <= 1'b0;
            bse_q  <= 4'h0;
            addr_q <= '0;
        end else begin
            state  <= state_next;
            read_q <= read_next;
            bse_q  <= bse_next;
            addr_q <= addr_next;
        end
    end

    // Prefetch buffer and span-boundary presentation; a capture on the
    // present cycle lands after the old buffer has been handed over.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            fetch_buf   <= '0;
            buf_valid   <= 1'b0;
            data_to_VGA <= '0;
        end else if (!visible) begin
            buf_valid   <= 1'b0;
            data_to_VGA <= '0;
        end else begin
            if (present_hit) begin
                data_to_VGA <= buf_valid ? fetch_buf : '0;
                buf_valid   <= 1'b0;
            end
            if (capture) begin
                fetch_buf <= mask_bytes(sram.data_from_SRAM, sram.byte_select_in);
                buf_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_vga_data_controller.sv
// Directed plus randomized bench for the VGA span fetch engine, checked
// against a span-level behavioural model of the fetch/present rules.
module tb_vga_data_controller;
    import vga_pkg::*;

    logic        clk = 1'b0;
    logic        nrst = 1'b1;
    logic [31:0] req_addr = '0;
    logic [9:0]  h_count = '0;
    logic [1:0]  vga_state = 2'd0;
    logic [31:0] data_to_vga;

    vga_data_controller_if #(.ADDR_W(32), .DATA_W(32)) sram ();

    vga_data_controller #(
        .ADDR_W(32),
        .DATA_W(32),
        .FETCH_OFFSET(16)
    ) dut (
        .clk                 (clk),
        .nrst                (nrst),
        .VGA_request_address (req_addr),
        .h_count             (h_count),
        .VGA_state           (vga_state),
        .data_to_VGA         (data_to_vga),
        .sram                (sram)
    );

    // 25 MHz-style free-running pixel clock.
    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;
    int fails  = 0;
    int hc     = 0;
    int rises  = 0;
    logic prev_read = 1'b0;

    bit          force_data = 1'b0;
    logic [31:0] forced_data = '0;

    // Model: is a request outstanding, is a word buffered, and what is shown.
    bit          m_pending = 1'b0;
    bit          m_have    = 1'b0;
    logic [31:0] m_word    = '0;
    logic        m_read    = 1'b0;
    logic [31:0] m_addr    = '0;
    logic [31:0] m_data    = '0;

    function automatic logic [31:0] mem_word(input logic [31:0] n);
        case (n[1:0])
            2'd0:    return 32'h0000_0000;
            2'd1:    return 32'hFFFF_FFFF;
            2'd2:    return 32'h6AAA_5556;
            default: return {4{n[7:0]}};
        endcase
    endfunction

    function automatic logic [31:0] lane_mask(input logic [31:0] d, input logic [3:0] sel);
        return d & {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_output(input string pfx);
        check({pfx, "_read"}, {31'b0, sram.read}, {31'b0, m_read});
        check({pfx, "_bse"}, {28'b0, sram.byte_select_out}, m_read ? 32'hF : 32'h0);
        check({pfx, "_addr"}, sram.SRAM_address, m_addr);
        check({pfx, "_data"}, data_to_vga, m_data);
    endtask

    // Advances the model by one clock using the inputs the DUT just sampled.
    task automatic model_edge();
        bit vis;
        bit pres;
        vis  = (vga_state == 2'd1) || (vga_state == 2'd2);
        pres = (h_count[4:0] == 5'd31);
        if (!vis) begin
            m_pending = 1'b0;
            m_have    = 1'b0;
            m_data    = '0;
        end else begin
            if (pres) begin
                m_data = m_have ? m_word : 32'h0;
                m_have = 1'b0;
            end
            if (m_pending && sram.data_en) begin
                m_word    = lane_mask(sram.data_from_SRAM, sram.byte_select_in);
                m_have    = 1'b1;
                m_pending = 1'b0;
            end else if (m_pending && pres) begin
                m_pending = 1'b0;
            end else if (!m_pending && h_count[4:0] == 5'd16) begin
                m_pending = 1'b1;
                m_addr    = req_addr;
            end
        end
        m_read = m_pending;
    endtask

    // One pixel clock: drive h_count and SRAM data, clock, update model, compare.
    task automatic apply_stimulus();
        h_count = 10'(hc);
        sram.data_from_SRAM = force_data ? forced_data : mem_word(m_addr);
        @(posedge clk);
        model_edge();
        #1;
        check_output("cyc");
        if (sram.read && !prev_read) rises++;
        prev_read = sram.read;
        hc = (hc + 1) % 800;
    endtask

    initial begin
        sram.data_en        = 1'b0;
        sram.byte_select_in = 4'hF;
        sram.data_from_SRAM = '0;

        // Reset held with ACTIVE and launch position presented: nothing may move.
        #2;
        nrst = 1'b0;
        vga_state = 2'd2;
        h_count = 10'd16;
        sram.data_en = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1;
            check_output("reset");
        end
        nrst = 1'b1;

        // SYNC scan: no reads, blank data.
        vga_state = 2'd0;
        hc = 0;
        for (int i = 0; i < 200; i++) begin
            req_addr = 32'(i / 64);
            sram.data_en = 1'($urandom_range(0, 1));
            apply_stimulus();
        end
        check("sync_reads", 32'(rises), 32'd0);

        // BACKPORCH preload of address 1 with zero-wait SRAM.
        vga_state = 2'd1;
        req_addr = 32'd1;
        sram.data_en = 1'b1;
        hc = 0;
        rises = 0;
        for (int i = 0; i < 32; i++) begin
            apply_stimulus();
            if (i == 16) begin
                check("preload_read", {31'b0, sram.read}, 32'd1);
                check("preload_addr", sram.SRAM_address, 32'd1);
            end
            if (i == 17) check("preload_pulse_end", {31'b0, sram.read}, 32'd0);
        end
        check("preload_data", data_to_vga, 32'hFFFF_FFFF);
        check("preload_reads", 32'(rises), 32'd1);

        // ACTIVE line with address stepping every 64 pixels.
        vga_state = 2'd2;
        rises = 0;
        for (int i = 0; i < 640; i++) begin
            req_addr = 32'(i / 64);
            apply_stimulus();
            if (i % 32 == 31) check("active_word", data_to_vga, mem_word(32'((i / 32) / 2)));
        end
        check("active_reads", 32'(rises), 32'd20);

        // Byte lane masking on capture.
        force_data = 1'b1;
        forced_data = 32'hFFFF_FFFF;
        sram.byte_select_in = 4'b0101;
        for (int i = 0; i < 32; i++) apply_stimulus();
        check("byte_mask", data_to_vga, 32'h00FF_00FF);
        force_data = 1'b0;
        sram.byte_select_in = 4'hF;

        // Underrun: acknowledge never arrives within the span.
        sram.data_en = 1'b0;
        for (int i = 0; i < 32; i++) begin
            apply_stimulus();
            if (i == 30) check("underrun_pending", {31'b0, sram.read}, 32'd1);
        end
        check("underrun_data", data_to_vga, 32'h0);
        check("underrun_read", {31'b0, sram.read}, 32'd0);

        // Abort on entering FRONTPORCH mid-request.
        for (int i = 0; i < 32; i++) begin
            if (i == 20) vga_state = 2'd3;
            apply_stimulus();
            if (i == 19) check("abort_pending", {31'b0, sram.read}, 32'd1);
            if (i == 20) check("abort_read", {31'b0, sram.read}, 32'd0);
        end
        check("abort_data", data_to_vga, 32'h0);

        // Randomized phases, acknowledge latency, lane masks and data.
        for (int i = 0; i < 3000; i++) begin
            if (i % 50 == 0) vga_state = 2'($urandom_range(0, 3));
            req_addr = $urandom;
            sram.data_en = ($urandom_range(0, 3) != 0);
            sram.byte_select_in = 4'($urandom_range(0, 15));
            force_data = 1'($urandom_range(0, 1));
            forced_data = $urandom;
            apply_stimulus();
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/vga_data_controller.md
# vga_data_controller

Fetch engine between the VGA timing generator and the SRAM arbiter. Each 32-pixel span of a scan line gets one 32-bit word, at 1 bit per pixel, requested from SRAM. The word is fetched half a span early and presented to the pixel serializer on `data_to_VGA` exactly at the span boundary. Outside the visible region it issues no reads and drives blank data.

## Interface
- `ADDR_W`, 32, width of request and SRAM addresses
- `DATA_W`, 32, SRAM word width; pixels per word
- `FETCH_OFFSET`, 16, value of `h_count[4:0]` at which a prefetch launches
- `clk` input 1: pixel clock (25 MHz); single clock domain
- `nrst` input 1: asynchronous, active-low reset
- `VGA_request_address` input ADDR_W: word address for the next span, supplied by the timing/address generator
- `data_from_SRAM` input DATA_W: read data; valid when `data_en`=1
- `h_count` input 10: horizontal pixel counter; only bits [4:0] are used, and wrap is don't-care
- `VGA_state` input 2: 0 = SYNC, 1 = BACKPORCH, 2 = ACTIVE, 3 = FRONTPORCH
- `data_en` input 1: SRAM data-valid / read-acknowledge
- `byte_select_in` input 4: byte lane mask returned with the data; bit k covers bits [8k+7:8k]
- `byte_select_out` output 4: byte enables for the request; 4'hF while `read`=1, else 4'h0
- `read` output 1: SRAM read request; held until acknowledged
- `data_to_VGA` output DATA_W: current span's pixel word
- `SRAM_address` output ADDR_W: registered request address; holds its last value when idle

## Operation
- FSM states:
  - IDLE: no request pending. When `VGA_state` is 1 or 2 and `h_count[4:0]`==`FETCH_OFFSET`, register `SRAM_address`<=`VGA_request_address`, set `read`=1 and `byte_select_out`=4'hF, then go to REQ.
  - REQ: wait for acknowledge. On a cycle with `data_en`=1:
    - capture `fetch_buf` <= `data_from_SRAM` with unselected bytes zeroed;
    - set `buf_valid`=1;
    - drop `read` and `byte_select_out` to 0;
    - go to IDLE.
- Present: on a cycle with `VGA_state`∈{1,2} and `h_count[4:0]`==31:
  - if `buf_valid`, `data_to_VGA` <= `fetch_buf`;
  - otherwise (underrun) `data_to_VGA` <= 0.
  - `buf_valid` clears in both cases.
- Underrun with a request still in REQ: abort it. `read` drops and the FSM returns to IDLE.
- `VGA_state` 0 or 3:
  - any REQ aborts to IDLE;
  - `buf_valid` clears;
  - `data_to_VGA` <= 0 on the next edge.
- No fetch launches in SYNC or FRONTPORCH.
- A fetch launched in BACKPORCH preloads the first visible span.
- Capture and present in the same cycle: present takes the old `fetch_buf`. The new capture then sets `buf_valid`=1 for the following span.
- `VGA_state` changing mid-request: the abort rule above applies on the first cycle the state is 0 or 3.

## Timing
- Reset values: `read`=0, `byte_select_out`=0, `SRAM_address`=0, `data_to_VGA`=0, FSM=IDLE, `buf_valid`=0, `fetch_buf`=0.
- All outputs are registered.
- Launch-cycle edge: `read` rises and `SRAM_address` is valid on the edge that samples `h_count[4:0]`==16.
- Zero-wait SRAM (`data_en` tied 1): capture occurs one edge later and `read` is high for exactly 1 cycle.
- The request window is 15 cycles (h_count 17..31). Acknowledges after that underrun.
- Present edge: `data_to_VGA` changes on the edge sampling `h_count[4:0]`==31. The new word is therefore stable through `h_count[4:0]`==0..31 of the next span.
- Released after reset: normal operation starts on the first edge with `nrst`=1. There is no partial state.

## Structure
- Shared package `vga_pkg`:
  - `vga_state_t` enum (SYNC, BACKPORCH, ACTIVE, FRONTPORCH = 0..3);
  - `PIX_PER_WORD` = 32;
  - `FETCH_OFFSET` default;
  - `fetch_state_t` enum (IDLE, REQ).
- Single module; no sub-module is natural.
- The byte-mask-and-capture logic stays inline as one combinational function.

## Test plan
- Reset behaviour:
  - `nrst`=0 for 2 cycles -> all outputs 0.
  - `VGA_state`=2 asserted during reset -> `read` stays 0 until after release.
- SYNC scan (`VGA_state`=0, 200 cycles, address stepping every 64) -> `read` never 1 and `data_to_VGA`==0 throughout.
- BACKPORCH preload:
  - Setup: memory word n = {0, FFFFFFFF, 6AAA5556, n-pattern} by n mod 4; `VGA_request_address`=1; `data_en`=1; `byte_select_in`=4'hF.
  - Required:
    - one-cycle `read` pulse with `SRAM_address`=1 when `h_count[4:0]`==16;
    - `data_to_VGA`==FFFFFFFF after the next `h_count[4:0]`==31 edge.
- ACTIVE line (640 cycles, address incrementing every 64 cycles from 0) -> the presented words follow memory[0], memory[0], memory[1], memory[1], ... (0, 0, FFFFFFFF, FFFFFFFF, 6AAA5556, ...). There is exactly one `read` per span.
- Byte mask: `byte_select_in`=4'b0101 with data FFFFFFFF -> `data_to_VGA`==00FF00FF.
- Underrun: hold `data_en`=0 past `h_count[4:0]`==31 in ACTIVE -> `data_to_VGA`==0 for that span and `read` drops at the boundary. Switching `VGA_state` to 3 mid-request -> `read` drops next edge.
